// File: rtl/pulse_sync_tx_hs.sv
// rtl/pulse_sync_tx_hs.sv - multi-channel pulse-to-toggle launcher with req/ack handshake
//
// Purpose:
//   Each single-cycle pulse on a channel flips that channel's request toggle.
//   The channel then waits until the returned ack toggle, synchronised into
//   clk, matches the request before it launches again. Pulses that arrive
//   while a handshake is in flight are queued in a per-channel pending counter.
//
// Optional feature macro: PULSE_SYNC_TIMEOUT_EN
//   When defined, a per-channel watchdog abandons a handshake after
//   TIMEOUT_CYC cycles in WAIT_ACK and flags it on to_err.
//
// Ports:
//   clk       in   source-domain clock
//   rst_n     in   asynchronous active-low reset
//   pulse_in  in   [CH_NUM]        single-cycle event per channel
//   req_tgl   out  [CH_NUM]        registered request toggle to the far domain
//   ack_tgl   in   [CH_NUM]        ack toggle from the far domain (asynchronous)
//   busy      out  [CH_NUM]        channel in WAIT_ACK or pending count > 0
//   pend_cnt  out  [CH_NUM*CNT_W]  pending count, channel i at [i*CNT_W +: CNT_W]
//   ovf       out  [CH_NUM]        sticky overflow, a pulse was dropped
//   ovf_clr   in   clear all sticky error bits
//   to_err    out  [CH_NUM]        sticky handshake timeout (macro builds only)

module pulse_sync_tx_hs #(
    parameter int CH_NUM      = 4,
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 4,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [CH_NUM-1:0]       pulse_in,
    output logic [CH_NUM-1:0]       req_tgl,
    input  logic [CH_NUM-1:0]       ack_tgl,
    output logic [CH_NUM-1:0]       busy,
    output logic [CH_NUM*CNT_W-1:0] pend_cnt,
    output logic [CH_NUM-1:0]       ovf,
    input  logic                    ovf_clr
`ifdef PULSE_SYNC_TIMEOUT_EN
    ,
    output logic [CH_NUM-1:0]       to_err
`endif
);

    typedef enum logic {
        IDLE     = 1'b0,
        WAIT_ACK = 1'b1
    } state_e;

    localparam logic [CNT_W-1:0] PEND_MAX = '1;

    // Ack synchroniser: raw ack_tgl is only ever sampled by sync_q[0]
    logic [CH_NUM-1:0] sync_q [SYNC_STAGES];
    logic [CH_NUM-1:0] ack_s;

    state_e            state_q [CH_NUM];
    state_e            state_d [CH_NUM];
    logic [CNT_W-1:0]  pend_q  [CH_NUM];
    logic [CNT_W-1:0]  pend_d  [CH_NUM];
    logic [CH_NUM-1:0] req_q;
    logic [CH_NUM-1:0] req_d;
    logic [CH_NUM-1:0] ovf_q;
    logic [CH_NUM-1:0] ovf_d;
    logic [CH_NUM-1:0] ovf_set;

`ifdef PULSE_SYNC_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYC + 1);

    logic [WD_W-1:0]   wd_q [CH_NUM];
    logic [WD_W-1:0]   wd_d [CH_NUM];
    logic [CH_NUM-1:0] to_q;
    logic [CH_NUM-1:0] to_d;
    logic [CH_NUM-1:0] to_hit;
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT_CYC != 0);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                sync_q[s] <= '0;
            end
        end else begin
            sync_q[0] <= ack_tgl;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                sync_q[s] <= sync_q[s-1];
            end
        end
    end

    assign ack_s = sync_q[SYNC_STAGES-1];

    // Per-channel next-state logic
    always_comb begin
        req_d   = req_q;
        ovf_set = '0;
`ifdef PULSE_SYNC_TIMEOUT_EN
        to_hit  = '0;
`endif
        for (int i = 0; i < CH_NUM; i++) begin
            state_d[i] = state_q[i];
            pend_d[i]  = pend_q[i];
`ifdef PULSE_SYNC_TIMEOUT_EN
            wd_d[i]    = wd_q[i];
`endif
            case (state_q[i])
                IDLE: begin
                    if (pulse_in[i] || (pend_q[i] != '0)) begin
                        req_d[i]   = ~req_q[i];
                        state_d[i] = WAIT_ACK;
                        // A fresh pulse is launched directly; otherwise one
                        // queued pulse is consumed. With both, the count
                        // stays put (one consumed, one added).
                        if (!pulse_in[i]) begin
                            pend_d[i] = pend_q[i] - CNT_W'(1);
                        end
`ifdef PULSE_SYNC_TIMEOUT_EN
                        wd_d[i] = '0;
`endif
                    end
                end
                WAIT_ACK: begin
                    if (pulse_in[i]) begin
                        if (pend_q[i] == PEND_MAX) begin
                            ovf_set[i] = 1'b1;
                        end else begin
                            pend_d[i] = pend_q[i] + CNT_W'(1);
                        end
                    end
                    if (ack_s[i] == req_q[i]) begin
                        state_d[i] = IDLE;
                    end
`ifdef PULSE_SYNC_TIMEOUT_EN
                    else if (wd_q[i] == WD_W'(TIMEOUT_CYC - 1)) begin
                        // Abandon: realign the request with the returned ack
                        // so the next launch is a clean toggle.
                        req_d[i]   = ack_s[i];
                        state_d[i] = IDLE;
                        to_hit[i]  = 1'b1;
                    end else begin
                        wd_d[i] = wd_q[i] + WD_W'(1);
                    end
`endif
                end
            endcase
        end
    end

    // Set beats a same-cycle clear
    assign ovf_d = (ovf_q & ~{CH_NUM{ovf_clr}}) | ovf_set;
`ifdef PULSE_SYNC_TIMEOUT_EN
    assign to_d  = (to_q & ~{CH_NUM{ovf_clr}}) | to_hit;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_q <= '0;
            ovf_q <= '0;
            for (int i = 0; i < CH_NUM; i++) begin
                state_q[i] <= IDLE;
                pend_q[i]  <= '0;
            end
`ifdef PULSE_SYNC_TIMEOUT_EN
            to_q <= '0;
            for (int i = 0; i < CH_NUM; i++) begin
                wd_q[i] <= '0;
            end
`endif
        end else begin
            req_q <= req_d;
            ovf_q <= ovf_d;
            for (int i = 0; i < CH_NUM; i++) begin
                state_q[i] <= state_d[i];
                pend_q[i]  <= pend_d[i];
            end
`ifdef PULSE_SYNC_TIMEOUT_EN
            to_q <= to_d;
            for (int i = 0; i < CH_NUM; i++) begin
                wd_q[i] <= wd_d[i];
            end
`endif
        end
    end

    // busy depends on registered state and count only, never on raw ack
    always_comb begin
        busy     = '0;
        pend_cnt = '0;
        for (int i = 0; i < CH_NUM; i++) begin
            busy[i]                    = (state_q[i] == WAIT_ACK) || (pend_q[i] != '0);
            pend_cnt[i*CNT_W +: CNT_W] = pend_q[i];
        end
    end

    assign req_tgl = req_q;
    assign ovf     = ovf_q;
`ifdef PULSE_SYNC_TIMEOUT_EN
    assign to_err  = to_q;
`endif

endmodule

// File: tb/tb_pulse_sync_tx_hs.sv
// tb/tb_pulse_sync_tx_hs.sv - directed self-checking bench for pulse_sync_tx_hs

module tb_pulse_sync_tx_hs;

    localparam int CH = 4;
    localparam int CW = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [CH-1:0]    pulse_in;
    logic [CH-1:0]    req_tgl;
    logic [CH-1:0]    ack_tgl;
    logic [CH-1:0]    busy;
    logic [CH*CW-1:0] pend_cnt;
    logic [CH-1:0]    ovf;
    logic             ovf_clr;
`ifdef PULSE_SYNC_TIMEOUT_EN
    logic [CH-1:0]    to_err;
`endif

    always #5 clk = ~clk;

    pulse_sync_tx_hs #(
        .CH_NUM      (CH),
        .SYNC_STAGES (2),
        .CNT_W       (CW),
        .TIMEOUT_CYC (16)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .pulse_in (pulse_in),
        .req_tgl  (req_tgl),
        .ack_tgl  (ack_tgl),
        .busy     (busy),
        .pend_cnt (pend_cnt),
        .ovf      (ovf),
        .ovf_clr  (ovf_clr)
`ifdef PULSE_SYNC_TIMEOUT_EN
        ,
        .to_err   (to_err)
`endif
    );

    // Far-domain model: ack follows req after dly[i] clocks, or holds ack_hold
    logic [7:0]    hist [CH];
    int            dly  [CH];
    logic [CH-1:0] lb_en;
    logic [CH-1:0] ack_hold;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < CH; i++) hist[i] <= '0;
        end else begin
            for (int i = 0; i < CH; i++) hist[i] <= {hist[i][6:0], req_tgl[i]};
        end
    end

    always_comb begin
        ack_tgl = '0;
        for (int i = 0; i < CH; i++) begin
            ack_tgl[i] = lb_en[i] ? hist[i][dly[i]-1] : ack_hold[i];
        end
    end

    int            checks   = 0;
    int            failures = 0;
    int            tgl_cnt [CH];
    logic [CH-1:0] last_req;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        for (int i = 0; i < CH; i++) begin
            if (req_tgl[i] !== last_req[i]) tgl_cnt[i]++;
        end
        last_req = req_tgl;
    endtask

    task automatic clr_tgl();
        for (int i = 0; i < CH; i++) tgl_cnt[i] = 0;
    endtask

    function automatic logic [CW-1:0] pend_of(input int ch);
        return pend_cnt[ch*CW +: CW];
    endfunction

    task automatic wait_idle(input int ch, input int budget);
        int n;
        n = 0;
        while (busy[ch] && n < budget) begin
            tick();
            n++;
        end
        check_eq("wait_idle_budget", {31'd0, busy[ch]}, 32'd0);
    endtask

    initial begin
        rst_n    = 1'b0;
        pulse_in = '0;
        ovf_clr  = 1'b0;
        lb_en    = '1;
        ack_hold = '0;
        dly      = '{3, 4, 3, 3};
        last_req = '0;
        clr_tgl();

        repeat (3) tick();
        check_eq("rst_req",  {28'd0, req_tgl}, 32'd0);
        check_eq("rst_busy", {28'd0, busy}, 32'd0);
        check_eq("rst_pend", {16'd0, pend_cnt}, 32'd0);
        check_eq("rst_ovf",  {28'd0, ovf}, 32'd0);
        rst_n = 1'b1;
        repeat (2) tick();

        // Single pulse on ch0, ack delay 3
        pulse_in = 4'b0001;
        tick();
        pulse_in = '0;
        check_eq("single_req_launch", {31'd0, req_tgl[0]}, 32'd1);
        check_eq("single_busy_start", {31'd0, busy[0]}, 32'd1);
        check_eq("single_pend", {28'd0, pend_of(0)}, 32'd0);
        repeat (5) tick();
        check_eq("single_busy_last", {31'd0, busy[0]}, 32'd1);
        tick();
        check_eq("single_busy_drop", {31'd0, busy[0]}, 32'd0);
        check_eq("single_toggles", tgl_cnt[0], 32'd1);

        // Burst of 5 on ch1, ack delay 4
        for (int k = 0; k < 5; k++) begin
            pulse_in = 4'b0010;
            tick();
        end
        pulse_in = '0;
        check_eq("burst_pend_peak", {28'd0, pend_of(1)}, 32'd4);
        check_eq("burst_first_launch", tgl_cnt[1], 32'd1);
        wait_idle(1, 200);
        check_eq("burst_toggles", tgl_cnt[1], 32'd5);
        check_eq("burst_req_final", {31'd0, req_tgl[1]}, 32'd1);
        check_eq("burst_pend_final", {28'd0, pend_of(1)}, 32'd0);
        check_eq("burst_ovf", {31'd0, ovf[1]}, 32'd0);

        // ch3: pulse coincides with ack completion while pend=2
        for (int k = 0; k < 3; k++) begin
            pulse_in = 4'b1000;
            tick();
        end
        pulse_in = '0;
        repeat (3) tick();
        check_eq("simul_pend_before", {28'd0, pend_of(3)}, 32'd2);
        pulse_in = 4'b1000;
        tick();
        pulse_in = '0;
        check_eq("simul_pend_after", {28'd0, pend_of(3)}, 32'd3);
        check_eq("simul_req_hold", {31'd0, req_tgl[3]}, 32'd1);
        tick();
        check_eq("simul_relaunch_req", {31'd0, req_tgl[3]}, 32'd0);
        check_eq("simul_relaunch_pend", {28'd0, pend_of(3)}, 32'd2);
        wait_idle(3, 200);
        check_eq("simul_toggles", tgl_cnt[3], 32'd4);

`ifndef PULSE_SYNC_TIMEOUT_EN
        // Saturation on ch2 with ack never returned
        lb_en[2]    = 1'b0;
        ack_hold[2] = 1'b0;
        for (int k = 0; k < 16; k++) begin
            pulse_in = 4'b0100;
            tick();
        end
        check_eq("sat_pend_full", {28'd0, pend_of(2)}, 32'd15);
        check_eq("sat_no_ovf_yet", {31'd0, ovf[2]}, 32'd0);
        tick();
        pulse_in = '0;
        check_eq("sat_pend_hold", {28'd0, pend_of(2)}, 32'd15);
        check_eq("sat_ovf_set", {28'd0, ovf}, 32'h4);
        check_eq("sat_one_launch", tgl_cnt[2], 32'd1);
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        check_eq("sat_ovf_clr", {31'd0, ovf[2]}, 32'd0);
        ovf_clr  = 1'b1;
        pulse_in = 4'b0100;
        tick();
        ovf_clr  = 1'b0;
        pulse_in = '0;
        check_eq("sat_set_wins", {31'd0, ovf[2]}, 32'd1);
`endif

        // Reset in the middle of a handshake
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        last_req    = '0;
        clr_tgl();
        lb_en[2]    = 1'b0;
        ack_hold[2] = 1'b0;
        for (int k = 0; k < 4; k++) begin
            pulse_in = 4'b0100;
            tick();
        end
        pulse_in = '0;
        check_eq("rstmid_pend", {28'd0, pend_of(2)}, 32'd3);
        check_eq("rstmid_req", {31'd0, req_tgl[2]}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("rstmid_async_req",  {28'd0, req_tgl}, 32'd0);
        check_eq("rstmid_async_busy", {28'd0, busy}, 32'd0);
        check_eq("rstmid_async_pend", {16'd0, pend_cnt}, 32'd0);
        check_eq("rstmid_async_ovf",  {28'd0, ovf}, 32'd0);
        repeat (2) tick();
        clr_tgl();
        rst_n = 1'b1;
        lb_en = '1;
        repeat (10) tick();
        check_eq("rstmid_no_toggle", tgl_cnt[0] + tgl_cnt[1] + tgl_cnt[2] + tgl_cnt[3], 32'd0);
        check_eq("rstmid_busy_after", {28'd0, busy}, 32'd0);

`ifdef PULSE_SYNC_TIMEOUT_EN
        // Watchdog on ch0 with ack held low
        lb_en[0]    = 1'b0;
        ack_hold[0] = 1'b0;
        pulse_in    = 4'b0001;
        tick();
        tick();
        pulse_in = '0;
        repeat (14) tick();
        check_eq("to_req_before", {31'd0, req_tgl[0]}, 32'd1);
        check_eq("to_err_before", {31'd0, to_err[0]}, 32'd0);
        tick();
        check_eq("to_req_revert", {31'd0, req_tgl[0]}, 32'd0);
        check_eq("to_err_set", {31'd0, to_err[0]}, 32'd1);
        check_eq("to_pend_kept", {28'd0, pend_of(0)}, 32'd1);
        tick();
        check_eq("to_relaunch_req", {31'd0, req_tgl[0]}, 32'd1);
        check_eq("to_relaunch_pend", {28'd0, pend_of(0)}, 32'd0);
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        check_eq("to_err_clr", {31'd0, to_err[0]}, 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
